// File: rtl/eb_src.sv
// Burst source: emits len words (base, base+1, ...) on a req/ack port,
// optionally inserting one-cycle LFSR-driven bubbles between words.
module eb_src #(
  parameter int W  = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  base,
  input  logic [15:0]   seed,
  input  logic          gap_en,
  output logic [W-1:0]  i_dat,
  output logic          i_req,
  input  logic          i_ack,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] sent,
  output logic [1:0]    o_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [15:0]   LFSR_DFLT = 16'hACE1;
  localparam logic [LW-1:0] REM_LAST  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  DAT_ONE   = {{(W-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [W-1:0]  r_dat;
  logic [LW-1:0] r_rem;
  logic [LW-1:0] r_sent;
  logic [15:0]   r_lfsr;
  logic          r_gap_en;

  logic          w_xfer;
  logic [15:0]   w_lfsr_next;

  // Handshake: a word moves on a rising edge where i_req and i_ack are both
  // high; once raised, i_req and i_dat hold until that edge.
  assign w_xfer      = (r_state == S_SEND) && i_ack;
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dat    <= '0;
      r_rem    <= '0;
      r_sent   <= '0;
      r_lfsr   <= LFSR_DFLT;
      r_gap_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sent <= '0;
            if (len != '0) begin
              r_rem    <= len;
              r_dat    <= base;
              r_lfsr   <= (seed == 16'h0000) ? LFSR_DFLT : seed;
              r_gap_en <= gap_en;
              r_state  <= S_SEND;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_dat  <= r_dat + DAT_ONE;
            r_sent <= r_sent + REM_LAST;
            r_rem  <= r_rem - REM_LAST;
            r_lfsr <= w_lfsr_next;
            // Bubble decision uses the LFSR value before this step.
            if (r_rem == REM_LAST)
              r_state <= S_DONE;
            else if (r_gap_en && r_lfsr[0])
              r_state <= S_GAP;
          end
        end
        S_GAP:   r_state <= S_SEND;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_dat   = r_dat;
  assign i_req   = (r_state == S_SEND);
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign sent    = r_sent;
  assign o_state = r_state;

endmodule
